pc_fetch_sequencer: RTL and testbench

- Consumer side of the branch/jump target path. Takes the jal, branch and jalr targets, plus the trap vectors, and owns the architectural PC.
- Issues instruction-memory fetches over a req/gnt/rvalid handshake and presents fetched instructions to decode with a valid/ready handshake.
- Sits between the target-address generator, the control unit, and instruction memory.

---
 rtl/pc_fetch_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Owns the architectural PC, fetches over req/gnt/rvalid and hands words to decode (valid/ready). Optional: PC_MISALIGN_TRAP_EN.
// Latency: 2 cycles from IMEM_REQ to IR_VALID with GNT in the first cycle and RVALID in the next.
// Backpressure: IR is held while IR_READY=0 and no new fetch is issued until decode consumes it.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REDIRECT,
  input  logic [2:0]  PC_SOURCE,
  input  logic [31:0] JAL,
  input  logic [31:0] BRANCH,
  input  logic [31:0] JALR,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  output logic        IR_VALID,
  input  logic        IR_READY,
  output logic        MISALIGN,
  output logic [31:0] MISALIGN_ADDR
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        ir_vld_q, ir_vld_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        stale_q, stale_d, stale_rst;
  logic        rv_live;

  logic        sel_vld;
  logic [31:0] sel_raw;
  logic [31:0] tgt;

  always_comb begin
    sel_vld = REDIRECT;
    sel_raw = 32'h0;
    case (PC_SOURCE)
      3'd1:    sel_raw = JALR & ~32'h1;
      3'd2:    sel_raw = BRANCH;
      3'd3:    sel_raw = JAL;
      3'd4:    sel_raw = MTVEC;
      3'd5:    sel_raw = MEPC;
      default: sel_vld = 1'b0;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic        mis_hit;
  logic        mis_q, mis_d;
  logic [31:0] mis_addr_q, mis_addr_d;

  // Only the computed targets can trap; trap vectors are just word-aligned.
  always_comb begin
    mis_hit    = sel_vld && (PC_SOURCE inside {3'd1, 3'd2, 3'd3}) && sel_raw[1];
    tgt        = mis_hit ? (MTVEC & 32'hFFFF_FFFC) : (sel_raw & 32'hFFFF_FFFC);
    mis_d      = mis_hit;
    mis_addr_d = mis_hit ? sel_raw : mis_addr_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mis_q      <= 1'b0;
      mis_addr_q <= 32'h0;
    end else begin
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign MISALIGN      = mis_q;
  assign MISALIGN_ADDR = mis_addr_q;
`else
  assign tgt           = sel_raw & 32'hFFFF_FFFC;
  assign MISALIGN      = 1'b0;
  assign MISALIGN_ADDR = 32'h0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_vld_d   = ir_vld_q;
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;
    // A response owed to a pre-reset request is consumed here and never reaches IR.
    rv_live    = IMEM_RVALID && !stale_q;
    stale_d    = stale_q && !IMEM_RVALID;

    case (state_q)
      S_REQ: begin
        if (sel_vld) begin
          pend_vld_d = 1'b1;
          pend_pc_d  = tgt;
        end
        if (req_q && IMEM_GNT) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rv_live) begin
          if (sel_vld) begin
            pc_d       = tgt;
            pend_vld_d = 1'b0;
            state_d    = S_REQ;
          end else if (pend_vld_q) begin
            pc_d       = pend_pc_q;
            pend_vld_d = 1'b0;
            state_d    = S_REQ;
          end else begin
            ir_d     = IMEM_RDATA;
            ir_pc_d  = pc_q;
            ir_vld_d = 1'b1;
            pc_d     = pc_q + 32'd4;
            state_d  = S_HOLD;
          end
        end else if (sel_vld) begin
          pend_vld_d = 1'b1;
          pend_pc_d  = tgt;
        end
      end
      S_HOLD: begin
        if (sel_vld) pc_d = tgt;
        if (IR_READY) begin
          ir_vld_d = 1'b0;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    req_d = (state_d == S_REQ);

    // At most one response can be in flight besides a stale one, so one bit suffices.
    stale_rst = (stale_q && !IMEM_RVALID)
             || (state_q == S_WAIT && !rv_live)
             || (state_q == S_REQ && req_q && IMEM_GNT);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_VECTOR;
      req_q      <= 1'b0;
      ir_q       <= 32'h0;
      ir_pc_q    <= 32'h0;
      ir_vld_q   <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= 32'h0;
      stale_q    <= stale_rst;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_vld_q   <= ir_vld_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
      stale_q    <= stale_d;
    end
  end

  assign IMEM_REQ  = req_q;
  assign IMEM_ADDR = pc_q;
  assign IR        = ir_q;
  assign IR_PC     = ir_pc_q;
  assign IR_VALID  = ir_vld_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: transaction-level expectation queues plus literal spot checks.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        RST_N = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [2:0]  PC_SOURCE = 3'd0;
  logic [31:0] JAL = 32'h0, BRANCH = 32'h0, JALR = 32'h0, MTVEC = 32'h0, MEPC = 32'h0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic [31:0] IR, IR_PC;
  logic        IR_VALID;
  logic        IR_READY = 1'b0;
  logic        MISALIGN;
  logic [31:0] MISALIGN_ADDR;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.RESET_VECTOR(RV)) dut (
    .CLK(clk), .RST_N(RST_N), .REDIRECT(REDIRECT), .PC_SOURCE(PC_SOURCE),
    .JAL(JAL), .BRANCH(BRANCH), .JALR(JALR), .MTVEC(MTVEC), .MEPC(MEPC),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .IR(IR), .IR_PC(IR_PC), .IR_VALID(IR_VALID), .IR_READY(IR_READY),
    .MISALIGN(MISALIGN), .MISALIGN_ADDR(MISALIGN_ADDR)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: next architectural fetch address and the transactions it implies.
  logic [31:0] m_pc = RV;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_ir_q[$];
  logic [31:0] exp_mis_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_none(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h, expected no transaction", name, act);
  endtask

  // Per-cycle compare against the expectation queues and handshake rules.
  logic        p_vld = 1'b0, p_req_hold = 1'b0, p_ir_hold = 1'b0;
  logic [31:0] p_addr = 32'h0, p_ir = 32'h0, p_irpc = 32'h0;

  always @(negedge clk) begin
    if (RST_N !== 1'b1) begin
      p_vld = 1'b0;
    end else begin
      if (p_vld && p_req_hold) begin
        chk("req_held", {31'b0, IMEM_REQ}, 32'd1);
        chk("addr_stable", IMEM_ADDR, p_addr);
      end
      if (p_vld && p_ir_hold) begin
        chk("ir_valid_held", {31'b0, IR_VALID}, 32'd1);
        chk("ir_stable", IR, p_ir);
        chk("ir_pc_stable", IR_PC, p_irpc);
      end
      chk("req_excl_irvalid", {31'b0, IMEM_REQ & IR_VALID}, 32'd0);
      if (IMEM_REQ && IMEM_GNT) begin
        if (exp_addr_q.size() == 0) chk_none("fetch_addr", IMEM_ADDR);
        else chk("fetch_addr", IMEM_ADDR, exp_addr_q.pop_front());
      end
      if (IR_VALID && IR_READY) begin
        if (exp_ir_q.size() == 0) chk_none("ir_deliver", IR);
        else begin
          logic [63:0] e;
          e = exp_ir_q.pop_front();
          chk("ir_data", IR, e[63:32]);
          chk("ir_pc", IR_PC, e[31:0]);
        end
      end
      if (MISALIGN) begin
        if (exp_mis_q.size() == 0) chk_none("misalign_pulse", MISALIGN_ADDR);
        else chk("misalign_addr", MISALIGN_ADDR, exp_mis_q.pop_front());
      end
      p_req_hold = IMEM_REQ && !IMEM_GNT;
      p_ir_hold  = IR_VALID && !IR_READY;
      p_addr     = IMEM_ADDR;
      p_ir       = IR;
      p_irpc     = IR_PC;
      p_vld      = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20 && IMEM_REQ !== 1'b1; k++) tick();
    chk("req_seen", {31'b0, IMEM_REQ}, 32'd1);
  endtask

  task automatic grant();
    wait_req();
    exp_addr_q.push_back(m_pc);
    IMEM_GNT = 1'b1;
    tick();
    IMEM_GNT = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input bit squash);
    IMEM_RVALID = 1'b1;
    IMEM_RDATA  = d;
    if (!squash) begin
      exp_ir_q.push_back({d, m_pc});
      m_pc = m_pc + 32'd4;
    end
    tick();
    IMEM_RVALID = 1'b0;
  endtask

  task automatic consume();
    IR_READY = 1'b1;
    tick();
    IR_READY = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] d);
    grant();
    respond(d, 1'b0);
    consume();
  endtask

  task automatic redirect(input logic [2:0] src);
    REDIRECT  = 1'b1;
    PC_SOURCE = src;
    tick();
    REDIRECT  = 1'b0;
    PC_SOURCE = 3'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    chk("rst_req", {31'b0, IMEM_REQ}, 32'd0);
    chk("rst_addr", IMEM_ADDR, RV);
    chk("rst_ir", IR, 32'h0);
    chk("rst_ir_pc", IR_PC, 32'h0);
    chk("rst_ir_valid", {31'b0, IR_VALID}, 32'd0);
    chk("rst_misalign", {31'b0, MISALIGN}, 32'd0);
    chk("rst_misalign_addr", MISALIGN_ADDR, 32'h0);
    RST_N = 1'b1;
    m_pc  = RV;

    // First fetch at minimum latency.
    wait_req();
    chk("t1_addr", IMEM_ADDR, 32'h0);
    grant();
    respond(32'h0050_0093, 1'b0);
    chk("t1_ir_valid", {31'b0, IR_VALID}, 32'd1);
    chk("t1_ir", IR, 32'h0050_0093);
    chk("t1_ir_pc", IR_PC, 32'h0);
    chk("t1_no_req", {31'b0, IMEM_REQ}, 32'd0);
    consume();
    chk("t1_next_req", {31'b0, IMEM_REQ}, 32'd1);
    chk("t1_next_addr", IMEM_ADDR, 32'h4);

    // Decode stalls for five cycles.
    grant();
    respond(32'h00A0_0113, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_ir", IR, 32'h00A0_0113);
      chk("t2_ir_pc", IR_PC, 32'h4);
      chk("t2_ir_valid", {31'b0, IR_VALID}, 32'd1);
      chk("t2_no_req", {31'b0, IMEM_REQ}, 32'd0);
      tick();
    end
    consume();

    // Branch taken in the same cycle decode consumes IR_PC=0x10.
    fetch(32'h0000_0013);
    fetch(32'h0010_0093);
    grant();
    respond(32'h0020_0113, 1'b0);
    chk("t3_ir_pc", IR_PC, 32'h10);
    BRANCH = 32'h40; PC_SOURCE = 3'd2; REDIRECT = 1'b1; IR_READY = 1'b1;
    tick();
    REDIRECT = 1'b0; PC_SOURCE = 3'd0; IR_READY = 1'b0;
    m_pc = 32'h40;
    chk("t3_req", {31'b0, IMEM_REQ}, 32'd1);
    chk("t3_addr", IMEM_ADDR, 32'h40);

    // Jal while waiting: the in-flight word is squashed.
    grant();
    JAL = 32'h80;
    redirect(3'd3);
    respond(32'hBAD0_0001, 1'b1);
    m_pc = 32'h80;
    chk("t4_ir_valid", {31'b0, IR_VALID}, 32'd0);
    chk("t4_req", {31'b0, IMEM_REQ}, 32'd1);
    chk("t4_addr", IMEM_ADDR, 32'h80);

    // Redirect coinciding with RVALID wins.
    grant();
    MEPC = 32'h200; REDIRECT = 1'b1; PC_SOURCE = 3'd5;
    respond(32'hBAD0_0002, 1'b1);
    REDIRECT = 1'b0; PC_SOURCE = 3'd0;
    m_pc = 32'h200;
    chk("t5_ir_valid", {31'b0, IR_VALID}, 32'd0);
    chk("t5_addr", IMEM_ADDR, 32'h200);

    // Redirects during S_REQ leave the address alone; the later one wins.
    wait_req();
    MTVEC = 32'h300;
    redirect(3'd4);
    chk("t6_addr_kept", IMEM_ADDR, 32'h200);
    BRANCH = 32'h401;
    redirect(3'd2);
    chk("t6_addr_kept2", IMEM_ADDR, 32'h200);
    grant();
    respond(32'hBAD0_0003, 1'b1);
    m_pc = 32'h400;
    chk("t6_addr", IMEM_ADDR, 32'h400);

    // PC_SOURCE=6 is not a redirect.
    grant();
    respond(32'h0030_0193, 1'b0);
    JAL = 32'h999; REDIRECT = 1'b1; PC_SOURCE = 3'd6;
    tick();
    REDIRECT = 1'b0; PC_SOURCE = 3'd0;
    consume();
    chk("t7_addr", IMEM_ADDR, 32'h404);

    // Misaligned jalr applied while decode stalls.
    grant();
    respond(32'h0040_0213, 1'b0);
    JALR = 32'h103;
`ifdef PC_MISALIGN_TRAP_EN
    exp_mis_q.push_back(32'h102);
    m_pc = 32'h300;
`else
    m_pc = 32'h100;
`endif
    redirect(3'd1);
    tick();
    chk("t8_ir_kept", IR_PC, 32'h404);
    chk("t8_ir_valid", {31'b0, IR_VALID}, 32'd1);
    consume();
`ifdef PC_MISALIGN_TRAP_EN
    chk("t8_addr", IMEM_ADDR, 32'h300);
`else
    chk("t8_addr", IMEM_ADDR, 32'h100);
`endif

    // Sequential increment wraps at the top of the address space.
    JAL = 32'hFFFF_FFFC;
    redirect(3'd3);
    grant();
    respond(32'hBAD0_0004, 1'b1);
    m_pc = 32'hFFFF_FFFC;
    fetch(32'h0050_0293);
    chk("t9_wrap_addr", IMEM_ADDR, 32'h0);

    // Reset with a grant outstanding; the late response must be dropped.
    grant();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    m_pc  = RV;
    wait_req();
    chk("t10_addr", IMEM_ADDR, RV);
    grant();
    IMEM_RVALID = 1'b1; IMEM_RDATA = 32'hDEAD_BEEF;
    tick();
    IMEM_RVALID = 1'b0;
    chk("t10_stale_ir_valid", {31'b0, IR_VALID}, 32'd0);
    chk("t10_stale_addr", IMEM_ADDR, RV);
    respond(32'h0060_0313, 1'b0);
    chk("t10_ir", IR, 32'h0060_0313);
    chk("t10_ir_pc", IR_PC, RV);
    consume();

    tick();
    tick();
    chk("end_addr_q", exp_addr_q.size(), 32'd0);
    chk("end_ir_q", exp_ir_q.size(), 32'd0);
    chk("end_mis_q", exp_mis_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
